// File: rtl/sc_regbus_pkg.sv
// Shared definitions for the register-bus sink: default sizes, occupancy
// state encoding and a constant clog2 helper for sizing pointers and counters.
package sc_regbus_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'b00,
        OCC_PARTIAL = 2'b01,
        OCC_FULL    = 2'b10
    } occ_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/sc_regbus_sink_mem.sv
// Storage array for the register-bus sink: falling-edge write port and an
// asynchronous read port so the head word falls through without a clock.
module sc_regbus_sink_mem
    import sc_regbus_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DEFAULT_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH
) (
    input  logic                      clk_50,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [DATAWIDTH_BUS-1:0]  wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [DATAWIDTH_BUS-1:0]  rdata
);

    logic [DATAWIDTH_BUS-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers and count,
    // so clearing the array would only cost a reset net on every bit.
    always_ff @(negedge clk_50) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sc_regbus_sink.sv
// Register-bus sink: captures bus words on a load strobe into a small FIFO and
// presents them first-word-fall-through on a valid/ready interface.
module sc_regbus_sink
    import sc_regbus_pkg::*;
#(
    parameter int                       DATAWIDTH_BUS    = DEFAULT_WIDTH,
    parameter int                       DEPTH            = DEFAULT_DEPTH,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_EMPTY_VALUE = '0
) (
    input  logic                      clk_50,
    input  logic                      SC_RegFIXED_Reset_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]  bus_data_in,
    input  logic                      bus_load_in,
    output logic                      bus_full_out,
    input  logic                      clear_in,
    output logic [DATAWIDTH_BUS-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [clog2(DEPTH):0]     count_out,
    output logic                      overflow_out
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    occ_state_e       state_q, state_d;

    logic                     push, pop, mem_we;
    logic [DATAWIDTH_BUS-1:0] mem_rdata;

    assign out_valid    = (state_q != OCC_EMPTY);
    assign bus_full_out = (state_q == OCC_FULL);
    assign pop          = out_valid && out_ready;
    // A full FIFO still accepts a load when the head leaves at the same edge.
    assign push         = bus_load_in && (!bus_full_out || pop);
    assign mem_we       = push && !clear_in;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear_in) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (bus_load_in && !push) overflow_d = 1'b1;
        end

        if (count_d == '0)                 state_d = OCC_EMPTY;
        else if (count_d == CNT_W'(DEPTH)) state_d = OCC_FULL;
        else                               state_d = OCC_PARTIAL;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(negedge clk_50 or posedge SC_RegFIXED_Reset_InHigh) begin
        if (SC_RegFIXED_Reset_InHigh) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= OCC_EMPTY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    sc_regbus_sink_mem #(
        .DATAWIDTH_BUS(DATAWIDTH_BUS),
        .DEPTH        (DEPTH)
    ) u_mem (
        .clk_50(clk_50),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (bus_data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign out_data     = out_valid ? mem_rdata : DATA_EMPTY_VALUE;
    assign count_out    = count_q;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_sc_regbus_sink.sv
// Self-checking bench for sc_regbus_sink: directed scenarios plus randomized
// traffic, all compared against a queue-based FIFO model.
module tb_sc_regbus_sink;

    localparam int DEPTH = 4;

    logic        clk_50;
    logic        rst;
    logic [31:0] bus_data_in;
    logic        bus_load_in;
    logic        bus_full_out;
    logic        clear_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count_out;
    logic        overflow_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_q [$];
    bit          ovf_m;
    logic [37:0] obs;
    logic [37:0] exp_v;

    sc_regbus_sink dut (
        .clk_50                  (clk_50),
        .SC_RegFIXED_Reset_InHigh(rst),
        .bus_data_in             (bus_data_in),
        .bus_load_in             (bus_load_in),
        .bus_full_out            (bus_full_out),
        .clear_in                (clear_in),
        .out_data                (out_data),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .count_out               (count_out),
        .overflow_out            (overflow_out)
    );

    initial begin
        clk_50 = 1'b1;
        forever #10 clk_50 = ~clk_50;
    end

    // Reference: a plain queue with the accept/drop/clear rules applied per edge.
    task automatic model_edge(input bit load, input logic [31:0] d, input bit ready, input bit clr);
        bit pop, full;
        pop  = (model_q.size() != 0) && ready;
        full = (model_q.size() == DEPTH);
        if (clr) begin
            model_q.delete();
            ovf_m = 1'b0;
        end else begin
            if (pop) void'(model_q.pop_front());
            if (load && (!full || pop)) model_q.push_back(d);
            else if (load) ovf_m = 1'b1;
        end
    endtask

    function automatic logic [37:0] exp_vec();
        int n;
        n = model_q.size();
        return {n != 0, n == DEPTH, ovf_m, 3'(n), (n != 0) ? model_q[0] : 32'h0};
    endfunction

    // Apply inputs, take one falling edge, update the model, sample 1 ns later.
    task automatic drive(input bit load, input logic [31:0] d, input bit ready, input bit clr);
        bus_load_in = load;
        bus_data_in = d;
        out_ready   = ready;
        clear_in    = clr;
        @(negedge clk_50);
        model_edge(load, d, ready, clr);
        #1;
        bus_load_in = 1'b0;
        out_ready   = 1'b0;
        clear_in    = 1'b0;
        bus_data_in = $urandom;
        obs   = {out_valid, bus_full_out, overflow_out, count_out, out_data};
        exp_v = exp_vec();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_load_in = 1'b0; clear_in = 1'b0; out_ready = 1'b0; bus_data_in = '0;
        #25;
        obs = {out_valid, bus_full_out, overflow_out, count_out, out_data};
        n_tests++;
        if (obs !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, 38'h0);
        end
        @(posedge clk_50);
        rst = 1'b0;
        model_q.delete();
        ovf_m = 1'b0;
        drive(0, 32'h0, 0, 0);
        n_tests++;
        if (obs !== 38'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, 38'h0);
        end
    endtask

    task automatic test_single();
        drive(1, 32'hA5A5A5A5, 0, 0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || count_out !== 3'd1) begin
            n_fail++;
            $display("FAIL single_load: got v=%0b d=%h c=%0d expected v=1 d=a5a5a5a5 c=1", out_valid, out_data, count_out);
        end
        drive(0, 32'h0, 1, 0);
        n_tests++;
        if (out_valid !== 1'b0 || count_out !== 3'd0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL single_pop: got v=%0b c=%0d d=%h expected v=0 c=0 d=0", out_valid, count_out, out_data);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) drive(1, 32'(i), 0, 0);
        n_tests++;
        if (bus_full_out !== 1'b1 || count_out !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_full: got full=%0b c=%0d expected full=1 c=4", bus_full_out, count_out);
        end
        drive(1, 32'h5, 0, 0);
        n_tests++;
        if (overflow_out !== 1'b1 || count_out !== 3'd4 || out_data !== 32'h1) begin
            n_fail++;
            $display("FAIL overflow_drop: got ovf=%0b c=%0d d=%h expected ovf=1 c=4 d=1", overflow_out, count_out, out_data);
        end
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got v=%0b d=%h expected v=1 d=%h", i, out_valid, out_data, 32'(i));
            end
            drive(0, 32'h0, 1, 0);
        end
        n_tests++;
        if (out_valid !== 1'b0 || count_out !== 3'd0 || overflow_out !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: got v=%0b c=%0d ovf=%0b expected v=0 c=0 ovf=1", out_valid, count_out, overflow_out);
        end
        drive(0, 32'h0, 0, 1);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) drive(1, 32'h10 + 32'(i), 0, 0);
        drive(1, 32'hBEEF, 1, 0);
        n_tests++;
        if (count_out !== 3'd4 || overflow_out !== 1'b0 || out_data !== 32'h11) begin
            n_fail++;
            $display("FAIL full_push_pop: got c=%0d ovf=%0b d=%h expected c=4 ovf=0 d=11", count_out, overflow_out, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %h expected %h", i, obs, exp_v);
            end
            if (i == 3 && out_data !== 32'hBEEF) begin
                n_fail++;
                $display("FAIL beef_last: got %h expected 0000beef", out_data);
            end
            drive(0, 32'h0, 1, 0);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0);
        drive(0, 32'h0, 1, 0);
        n_tests++;
        if (count_out !== 3'd3 || overflow_out !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_setup: got c=%0d ovf=%0b expected c=3 ovf=1", count_out, overflow_out);
        end
        drive(1, 32'hDEAD, 0, 1);
        n_tests++;
        if (obs !== 38'h0) begin
            n_fail++;
            $display("FAIL clear_priority: got %h expected %h", obs, 38'h0);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 32'hA, 0, 0);
        drive(1, 32'hB, 0, 0);
        #5;
        rst = 1'b1;
        #1;
        model_q.delete();
        ovf_m = 1'b0;
        obs = {out_valid, bus_full_out, overflow_out, count_out, out_data};
        n_tests++;
        if (obs !== 38'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs, 38'h0);
        end
        #2;
        rst = 1'b0;
        drive(1, 32'h7, 0, 0);
        n_tests++;
        if (out_data !== 32'h7 || count_out !== 3'd1) begin
            n_fail++;
            $display("FAIL load_after_reset: got d=%h c=%0d expected d=7 c=1", out_data, count_out);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, 32'h100 + 32'(i), 1, 0);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 3) != 0, $urandom, ($urandom % 2) != 0, ($urandom % 40) == 0);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_regbus_sink.md
Name: sc_regbus_sink

Overview:
- Bus-side consumer for the micro-datapath register bus. It is the receiving end of constant and general registers that drive DataBUS.
- Captures the word on the bus when a load strobe is asserted and buffers it in a small FIFO.
- Presents buffered words to a downstream unit (ALU operand latch or debug port) through a valid/ready handshake.
- Sits between the bus multiplexer and the datapath consumers. Decouples bus-source timing from consumer timing.

Parameters:
- DATAWIDTH_BUS, 32, width of bus words.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- DATA_EMPTY_VALUE, 32'h00000000, value driven on out_data while the FIFO is empty.

Ports:
- clk_50  input  1  system clock; all state updates on the falling edge.
- SC_RegFIXED_Reset_InHigh  input  1  reset, asynchronous, active-high.
- bus_data_in  input  DATAWIDTH_BUS  word currently driven on the register bus.
- bus_load_in  input  1  capture strobe; samples bus_data_in at the falling edge.
- bus_full_out  output  1  FIFO full; the bus controller must not load.
- clear_in  input  1  synchronous flush.
- out_data  output  DATAWIDTH_BUS  head entry (first-word fall-through).
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- count_out  output  log2(DEPTH)+1  number of stored entries.
- overflow_out  output  1  sticky flag: a load was dropped.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, mid-operation included):
  - write pointer, read pointer and count = 0.
  - out_valid = 0, bus_full_out = 0, overflow_out = 0, out_data = DATA_EMPTY_VALUE.
  - Stored contents are discarded.
- All non-reset updates occur on the negedge of clk_50.
- Occupancy FSM (derived from count): EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - out_valid = (state != EMPTY).
  - bus_full_out = (state == FULL).
- pop = out_valid && out_ready.
- push = bus_load_in && (!bus_full_out || pop).
  - When FULL, a simultaneous pop and load is accepted and count stays at DEPTH.
- Simultaneous push and pop in PARTIAL: count unchanged, both pointers advance.
- Push in EMPTY: the word appears on out_data and out_valid rises immediately after that same edge. Capture-to-output latency is one falling edge.
- Overflow: bus_load_in while FULL and no pop → the word is dropped, state is unchanged, overflow_out is set and held until clear_in or reset.
- clear_in has priority over push and pop at the same edge. It empties the FIFO, resets the pointers and clears overflow_out. A load at that edge is discarded.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. count is a separate register, never inferred from pointer difference.
- out_data is combinational from the storage array at the read pointer. It shows DATA_EMPTY_VALUE while EMPTY.
- out_data and out_valid have no combinational dependence on bus_data_in or bus_load_in.
- Stored data is never modified while resident.

Decomposition:
- Shared package sc_regbus_pkg holds:
  - default width and depth constants;
  - the occupancy state encoding: EMPTY=2'b00, PARTIAL=2'b01, FULL=2'b10;
  - a clog2 helper constant function.
- One sub-module, sc_regbus_sink_mem:
  - DEPTH x DATAWIDTH_BUS storage array;
  - negedge write port (we, waddr, wdata) and asynchronous read port (raddr, rdata);
  - no reset on the storage contents.
- Pointer, count, FSM and flag logic stay in sc_regbus_sink.

Test Plan:
- Reset then idle → out_valid=0, count_out=0, out_data=32'h00000000, bus_full_out=0, overflow_out=0.
- Load 32'hA5A5A5A5 with out_ready=0 → after one falling edge out_valid=1, out_data=32'hA5A5A5A5, count_out=1; then out_ready=1 for one edge → count_out=0, out_valid=0.
- Load 32'h1, 32'h2, 32'h3, 32'h4 with out_ready=0 → bus_full_out=1, count_out=4. A fifth load of 32'h5 → overflow_out=1, count_out=4. Drain order is 1,2,3,4; 32'h5 never appears.
- FULL with simultaneous load 32'hBEEF and out_ready=1 → count_out stays 4, overflow_out stays 0, head becomes the second entry. 32'hBEEF drains last.
- Assert clear_in together with bus_load_in=1 while count_out=3 and overflow_out=1 → count_out=0, overflow_out=0, out_valid=0, loaded word discarded.
- Assert reset asynchronously between edges with count_out=2 → outputs return to reset values immediately, without waiting for a clock edge. Loading 32'h7 after reset release yields out_data=32'h7 with count_out=1, and pointers wrap correctly across more than 8 push/pop cycles.
